// File: rtl/micro_pkg.sv
// rtl/micro_pkg.sv - shared FSM state type and default sizing for mem_resp
package micro_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int DEFAULT_DEPTH = 256;
  localparam int DEFAULT_WAIT  = 2;

endpackage

// File: rtl/mem_resp_array.sv
// rtl/mem_resp_array.sv - synchronous single-port word store for mem_resp
module mem_resp_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  // The read register holds a word only for the cycle after a read strobe, so it reads 0 otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[idx];
    else         rdata <= '0;
  end

endmodule

// File: rtl/mem_resp.sv
// rtl/mem_resp.sv - wait-state memory responder with req/ack handshake
// Optional address checking with MEM_RESP_ERR_EN.
module mem_resp
  import micro_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WAIT  = DEFAULT_WAIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        go_resp;
  logic        bad;
  logic        mem_we;
  logic        mem_re;

  assign go_resp = (state == BUSY) && (cnt == 4'd0);

`ifdef MEM_RESP_ERR_EN
  assign bad = (lat_addr[1:0] != 2'b00) || (lat_addr >= 32'(DEPTH * 4));
`else
  logic unused_addr;
  assign bad         = 1'b0;
  assign err         = 1'b0;
  assign unused_addr = ^{lat_addr[31:AW+2], lat_addr[1:0]};
`endif

  // The array access happens on the edge entering RESP, so its output lines up with ack.
  assign mem_we = go_resp && lat_we && !bad;
  assign mem_re = go_resp && !lat_we && !bad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ack       <= 1'b0;
      busy      <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
`ifdef MEM_RESP_ERR_EN
      err       <= 1'b0;
`endif
    end else begin
      ack <= 1'b0;
`ifdef MEM_RESP_ERR_EN
      err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req) begin
            state     <= BUSY;
            busy      <= 1'b1;
            cnt       <= 4'(WAIT);
            lat_we    <= we;
            lat_addr  <= addr;
            lat_wdata <= wdata;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state <= RESP;
            ack   <= 1'b1;
`ifdef MEM_RESP_ERR_EN
            err   <= bad;
`endif
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  mem_resp_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .re    (mem_re),
    .idx   (lat_addr[AW+1:2]),
    .wdata (lat_wdata),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_mem_resp.sv
// tb/tb_mem_resp.sv - directed checks of mem_resp at WAIT=2 and WAIT=0
module tb_mem_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        req_a, we_a, ack_a, err_a, busy_a;
  logic [31:0] addr_a, wdata_a, rdata_a;
  logic        req_b, we_b, ack_b, err_b, busy_b;
  logic [31:0] addr_b, wdata_b, rdata_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_resp #(.DEPTH(256), .WAIT(2)) u_a (
    .clk(clk), .rst(rst), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
    .rdata(rdata_a), .ack(ack_a), .err(err_a), .busy(busy_a)
  );

  mem_resp #(.DEPTH(256), .WAIT(0)) u_b (
    .clk(clk), .rst(rst), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
    .rdata(rdata_b), .ack(ack_b), .err(err_b), .busy(busy_b)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // One transaction on the WAIT=2 instance; entered and left at posedge+1 with the FSM idle.
  task automatic txn_a(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_e, input bit scramble);
    int lat;
    req_a = 1'b1; we_a = w; addr_a = a; wdata_a = d;
    @(posedge clk); #1;
    check({tag, " busy"}, 32'(busy_a), 32'd1);
    req_a = 1'b0;
    if (scramble) begin
      addr_a  = a + 32'h4;
      wdata_a = ~d;
      we_a    = ~w;
    end
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (ack_a) begin
        lat = k;
        break;
      end
    end
    check({tag, " lat"}, 32'(lat), 32'd3);
    check({tag, " rdata"}, rdata_a, exp_rd);
    check({tag, " err"}, 32'(err_a), 32'(exp_e));
    @(posedge clk); #1;
    check({tag, " ack_drop"}, 32'(ack_a), 32'd0);
    check({tag, " idle"}, 32'(busy_a), 32'd0);
    check({tag, " rdata_idle"}, rdata_a, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int seen;
    req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
    req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;

    vecs[0]  = '{1'b1, 32'h010, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h3FC, 32'h12345678, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h3FC, 32'h0,        32'h12345678, 1'b0};
    vecs[4]  = '{1'b1, 32'h000, 32'hA5A5A5A5, 32'h0,        1'b0};
    vecs[5]  = '{1'b1, 32'h004, 32'h22222222, 32'h0,        1'b0};
`ifdef MEM_RESP_ERR_EN
    vecs[6]  = '{1'b0, 32'h400, 32'h0,        32'h0,        1'b1};
    vecs[7]  = '{1'b0, 32'h013, 32'h0,        32'h0,        1'b1};
    vecs[8]  = '{1'b1, 32'h404, 32'h11111111, 32'h0,        1'b1};
    vecs[9]  = '{1'b0, 32'h004, 32'h0,        32'h22222222, 1'b0};
`else
    vecs[6]  = '{1'b0, 32'h400, 32'h0,        32'hA5A5A5A5, 1'b0};
    vecs[7]  = '{1'b0, 32'h013, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[8]  = '{1'b1, 32'h404, 32'h11111111, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 32'h004, 32'h0,        32'h11111111, 1'b0};
`endif
    vecs[10] = '{1'b0, 32'h000, 32'h0,        32'hA5A5A5A5, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst ack", 32'(ack_a), 32'd0);
    check("rst busy", 32'(busy_a), 32'd0);
    check("rst err", 32'(err_a), 32'd0);
    check("rst rdata", rdata_a, 32'd0);
    check("rst ack_b", 32'(ack_b), 32'd0);
    check("rst busy_b", 32'(busy_b), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++)
      txn_a($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
            vecs[i].exp_rdata, vecs[i].exp_err, 1'b0);

    txn_a("chg_w", 1'b1, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
    txn_a("chg_r", 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0);

    txn_a("pre_w", 1'b1, 32'h30, 32'h01020304, 32'h0, 1'b0, 1'b0);
    req_a = 1'b1; we_a = 1'b1; addr_a = 32'h30; wdata_a = 32'h99999999;
    @(posedge clk); #1;
    req_a = 1'b0;
    @(posedge clk); #1;
    check("mid busy", 32'(busy_a), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst ack", 32'(ack_a), 32'd0);
    check("mid_rst busy", 32'(busy_a), 32'd0);
    check("mid_rst rdata", rdata_a, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ack_a) seen = 1;
    end
    check("mid_rst no_ack", 32'(seen), 32'd0);
    txn_a("mid_rst rd", 1'b0, 32'h30, 32'h0, 32'h01020304, 1'b0, 1'b0);

    req_b = 1'b1; we_b = 1'b1; addr_b = 32'h40; wdata_b = 32'h5;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      check($sformatf("hold ack e%0d", k), 32'(ack_b), 32'((k % 3) == 2));
      check($sformatf("hold busy e%0d", k), 32'(busy_b), 32'((k % 3) != 0));
    end
    req_b = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
